mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Consumer end of the EX->MEM interface: takes the ALU result, store data and destination register from the execute stage and performs the RV32I load/store.
- Drives a data-memory request/grant/rvalid bus, aligns and extends load data, and stalls execute while an access is outstanding.
- Presents a registered one-cycle writeback record to the WB stage.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before aborting with bus error (1..65535)

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-low reset
valid_i  in  1  EX presents an instruction this cycle
alu_result_i  in  32  effective address, or result for non-memory ops
read_data2_i  in  32  store data (rs2)
write_reg_i  in  5  destination register
regwrite_i  in  1  instruction writes rd
memread_i  in  1  load
memwrite_i  in  1  store (memread_i&&memwrite_i: illegal)
funct3_i  in  3  width/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
stall_o  out  1  EX must hold its outputs
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  32  read data
wb_valid_o  out  1  writeback record valid (1-cycle pulse)
wb_data_o  out  32  load data or passed ALU result
wb_reg_o  out  5  destination register
wb_regwrite_o  out  1  write enable for WB
exc_o  out  1  with wb_valid_o: access aborted
exc_cause_o  out  2  0 misaligned, 1 illegal width/op, 2 bus timeout

Behaviour:
- Reset (reset_i=0, async):
  - State to IDLE; all outputs 0; timeout counter 0.
  - Any outstanding request is dropped. A late gnt/rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT.
  - stall_o = (state != IDLE), combinational.
  - dmem_req_o = (state == REQ).
- IDLE, valid_i=1: latch all inputs.
  - Non-memory op: next cycle wb_valid_o=1, wb_data_o=alu_result_i; stay IDLE.
  - Legal aligned memory op: go to REQ.
  - Misaligned or illegal op: no bus activity; next cycle wb_valid_o=1, exc_o=1, wb_regwrite_o=0.
    - Misaligned: W with addr[1:0]!=0, or H/HU with addr[0]!=0.
    - Illegal: load funct3 in {3,6,7}; store funct3 not in {0,1,2}; memread&&memwrite.
- REQ: hold dmem_* stable until dmem_gnt_i.
  - On gnt, store: go to IDLE; wb_valid_o=1 next cycle, wb_regwrite_o=0.
  - On gnt, load: go to WAIT.
- WAIT: on dmem_rvalid_i, capture extracted data; go to IDLE; wb_valid_o=1 next cycle.
  - rvalid in the same cycle as gnt is not legal bus behaviour and is ignored.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT: go to IDLE; next cycle wb_valid_o=1, exc_o=1, exc_cause_o=2, wb_regwrite_o=0.
- Byte enables by offset o=addr[1:0]:
  - B: be=1<<o.
  - H: be=o[1]?4'b1100:4'b0011.
  - W: 4'b1111.
  - be=0 for loads.
- Store data: B replicated {4{rs2[7:0]}}; H {2{rs2[15:0]}}; W rs2.
- Load extraction:
  - Byte: lane = rdata>>(8*o), then B/H sign-extend from bit 7/15, BU/HU zero-extend.
- wb_regwrite_o = latched regwrite_i && (wb_reg_o!=0) && !exc_o.
- wb_* outputs are registered and held until the next wb_valid_o pulse; only wb_valid_o returns to 0.
- Throughput:
  - Non-memory ops: 1 per cycle.
  - Store: 1 + gnt latency.
  - Load: 1 + gnt latency + rvalid latency.
  - A new instruction is accepted in the first cycle back in IDLE.

Test Plan:
- ALU pass-through: valid_i=1 for 3 consecutive cycles, memread/memwrite=0, results 1,2,3, rd=5 -> wb_valid_o 3 consecutive pulses, data 1,2,3, regwrite=1, stall_o never 1.
- SB: addr=0x1003, rs2=0xAABBCCDD, gnt after 2 cycles -> req held 3 cycles; addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD, we=1; stall_o=1 for 3 cycles; wb_regwrite_o=0.
- LB/LBU/LH: addr=0x2002, rdata=0x80F17F00, immediate gnt, rvalid 1 cycle later:
  - LB -> wb_data_o=0xFFFFFFF1.
  - LBU -> 0x000000F1.
  - LH -> 0xFFFF80F1.
  - rd=0 variant -> wb_regwrite_o=0.
- Misaligned LW at 0x2001 -> no dmem_req_o; next cycle wb_valid_o=1, exc_o=1, cause 0. Load with funct3=3 -> cause 1.
- Timeout: TIMEOUT=4, load with gnt never asserted -> after 4 REQ cycles return to IDLE; exc_o=1, cause 2; a subsequent ALU op completes normally.
- Reset mid-WAIT: load granted, reset_i pulsed low before rvalid -> outputs 0 immediately, state IDLE; a later rvalid produces no wb_valid_o.

Source files
------------

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I load/store unit on the EX->MEM boundary
// Drives a req/gnt/rvalid data bus and emits a registered one-cycle writeback record.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] read_data2_i,
  input  logic [4:0]  write_reg_i,
  input  logic        regwrite_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [2:0]  funct3_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_reg_o,
  output logic        wb_regwrite_o,
  output logic        exc_o,
  output logic [1:0]  exc_cause_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [31:0] alu_q;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        is_mem, illegal, misaligned, accept_mem, timeout_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, lane, load_data;
  logic        wb_fire, wb_exc_nxt, wb_rw_nxt;
  logic [1:0]  wb_cause_nxt;
  logic [31:0] wb_data_nxt;
  logic [4:0]  wb_reg_nxt;

  assign stall_o     = (state != IDLE);
  assign dmem_req_o  = (state == REQ);
  assign timeout_hit = (cnt == LAST);

  always_comb begin
    is_mem     = memread_i | memwrite_i;
    illegal    = (memread_i & memwrite_i)
               | (memread_i & ((funct3_i == 3'd3) | (funct3_i == 3'd6) | (funct3_i == 3'd7)))
               | (memwrite_i & (funct3_i > 3'd2));
    misaligned = ((funct3_i[1:0] == 2'd2) & (alu_result_i[1:0] != 2'd0))
               | ((funct3_i[1:0] == 2'd1) & alu_result_i[0]);
    accept_mem = valid_i & is_mem & ~illegal & ~misaligned;
    be_new     = 4'b1111;
    wdata_new  = read_data2_i;
    case (funct3_i[1:0])
      2'd0: begin
        be_new    = 4'b0001 << alu_result_i[1:0];
        wdata_new = {4{read_data2_i[7:0]}};
      end
      2'd1: begin
        be_new    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{read_data2_i[15:0]}};
      end
      default: ;
    endcase
    if (!memwrite_i) be_new = 4'b0000;
  end

  // Bring the addressed lane down to bit 0, then width/sign extend.
  always_comb begin
    lane = dmem_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_data = {24'd0, lane[7:0]};
      3'd5:    load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    wb_fire      = 1'b0;
    wb_exc_nxt   = 1'b0;
    wb_cause_nxt = 2'd0;
    wb_data_nxt  = alu_q;
    wb_reg_nxt   = rd_q;
    wb_rw_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i) begin
          wb_data_nxt = alu_result_i;
          wb_reg_nxt  = write_reg_i;
          if (!is_mem) begin
            wb_fire   = 1'b1;
            wb_rw_nxt = regwrite_i & (write_reg_i != 5'd0);
          end else if (illegal) begin
            wb_fire      = 1'b1;
            wb_exc_nxt   = 1'b1;
            wb_cause_nxt = 2'd1;
          end else if (misaligned) begin
            wb_fire      = 1'b1;
            wb_exc_nxt   = 1'b1;
            wb_cause_nxt = 2'd0;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          if (dmem_we_o) begin
            state_nxt = IDLE;
            wb_fire   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end else if (timeout_hit) begin
          state_nxt    = IDLE;
          wb_fire      = 1'b1;
          wb_exc_nxt   = 1'b1;
          wb_cause_nxt = 2'd2;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_nxt   = IDLE;
          wb_fire     = 1'b1;
          wb_data_nxt = load_data;
          wb_rw_nxt   = rw_q & (rd_q != 5'd0);
        end else if (timeout_hit) begin
          state_nxt    = IDLE;
          wb_fire      = 1'b1;
          wb_exc_nxt   = 1'b1;
          wb_cause_nxt = 2'd2;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt           <= 16'd0;
      alu_q         <= 32'd0;
      rd_q          <= 5'd0;
      rw_q          <= 1'b0;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
      dmem_we_o     <= 1'b0;
      dmem_addr_o   <= 32'd0;
      dmem_be_o     <= 4'd0;
      dmem_wdata_o  <= 32'd0;
      wb_valid_o    <= 1'b0;
      wb_data_o     <= 32'd0;
      wb_reg_o      <= 5'd0;
      wb_regwrite_o <= 1'b0;
      exc_o         <= 1'b0;
      exc_cause_o   <= 2'd0;
    end else begin
      cnt        <= (state == IDLE) ? 16'd0 : cnt + 16'd1;
      wb_valid_o <= wb_fire;
      if (wb_fire) begin
        wb_data_o     <= wb_data_nxt;
        wb_reg_o      <= wb_reg_nxt;
        wb_regwrite_o <= wb_rw_nxt;
        exc_o         <= wb_exc_nxt;
        exc_cause_o   <= wb_cause_nxt;
      end
      if (state == IDLE && valid_i) begin
        alu_q <= alu_result_i;
        rd_q  <= write_reg_i;
        rw_q  <= regwrite_i;
        f3_q  <= funct3_i;
        off_q <= alu_result_i[1:0];
      end
      // Bus fields only move when a new access starts, so they stay stable through REQ.
      if (state == IDLE && accept_mem) begin
        dmem_we_o    <= memwrite_i;
        dmem_addr_o  <= {alu_result_i[31:2], 2'b00};
        dmem_be_o    <= be_new;
        dmem_wdata_o <= wdata_new;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [31:0] alu_result_i, read_data2_i;
  logic [4:0]  write_reg_i;
  logic        regwrite_i, memread_i, memwrite_i;
  logic [2:0]  funct3_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_reg_o;
  logic        wb_regwrite_o, exc_o;
  logic [1:0]  exc_cause_o;

  always #5 clk_i = ~clk_i;

  mem_access #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i),
    .alu_result_i(alu_result_i), .read_data2_i(read_data2_i),
    .write_reg_i(write_reg_i), .regwrite_i(regwrite_i),
    .memread_i(memread_i), .memwrite_i(memwrite_i), .funct3_i(funct3_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_reg_o(wb_reg_o),
    .wb_regwrite_o(wb_regwrite_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        rw;
    logic        exc;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wb_count = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic chk, input logic [4:0] rd,
                      input logic rw, input logic exc, input logic [1:0] cause);
    exp_t x;
    x.data = data; x.chk_data = chk; x.rd = rd; x.rw = rw; x.exc = exc; x.cause = cause;
    sb.push_back(x);
  endtask

  always @(negedge clk_i) begin
    if (reset_i && wb_valid_o) begin
      wb_count++;
      if (sb.size() == 0) begin
        check("wb_spurious", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.chk_data) check("wb_data", wb_data_o, e.data);
        check("wb_reg", {27'd0, wb_reg_o}, {27'd0, e.rd});
        check("wb_regwrite", {31'd0, wb_regwrite_o}, {31'd0, e.rw});
        check("exc", {31'd0, exc_o}, {31'd0, e.exc});
        if (e.exc) check("exc_cause", {30'd0, exc_cause_o}, {30'd0, e.cause});
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    valid_i = 1'b1; alu_result_i = alu; read_data2_i = rs2; write_reg_i = rd;
    regwrite_i = rw; memread_i = mr; memwrite_i = mw; funct3_i = f3;
  endtask

  task automatic idle_in;
    valid_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0; regwrite_i = 1'b0;
  endtask

  // Plays the memory side while the DUT stalls; gnt_lat<0 or rv_lat==0 means never.
  task automatic bus(input int gnt_lat, input int rv_lat, input logic [31:0] rdata,
                     input int max_cyc, output int req_cyc, output int stall_cyc);
    int g = 0;
    int w = 0;
    req_cyc = 0;
    stall_cyc = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (!stall_o) break;
      stall_cyc++;
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b0;
      if (dmem_req_o) begin
        req_cyc++;
        if (g == gnt_lat) dmem_gnt_i = 1'b1;
        g++;
      end else begin
        w++;
        if (rv_lat > 0 && w == rv_lat) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i = rdata;
        end
      end
      tick();
    end
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    if (stall_o) check("bus_bound", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rq, st, base;
    logic [2:0]  ld_f3 [4] = '{3'd0, 3'd4, 3'd1, 3'd0};
    logic [4:0]  ld_rd [4] = '{5'd5, 5'd6, 5'd7, 5'd0};
    logic [31:0] ld_dt [4] = '{32'hFFFFFFF1, 32'h000000F1, 32'hFFFF80F1, 32'hFFFFFFF1};
    logic        ld_rw [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    reset_i = 1'b0;
    valid_i = 1'b0; alu_result_i = 32'd0; read_data2_i = 32'd0; write_reg_i = 5'd0;
    regwrite_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0; funct3_i = 3'd0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    #12;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_exc", {31'd0, exc_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    tick();

    base = wb_count;
    for (int i = 1; i <= 3; i++) begin
      drive(i, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0);
      push(i, 1'b1, 5'd5, 1'b1, 1'b0, 2'd0);
      check("alu_stall", {31'd0, stall_o}, 32'd0);
      tick();
    end
    idle_in();
    check("alu_stall_end", {31'd0, stall_o}, 32'd0);
    tick();
    check("alu_pulses", wb_count - base, 32'd3);

    drive(32'h1003, 32'hAABBCCDD, 5'd0, 1'b0, 1'b0, 1'b1, 3'd0);
    push(32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    tick();
    idle_in();
    check("sb_req", {31'd0, dmem_req_o}, 32'd1);
    check("sb_we", {31'd0, dmem_we_o}, 32'd1);
    check("sb_addr", dmem_addr_o, 32'h1000);
    check("sb_be", {28'd0, dmem_be_o}, 32'h8);
    check("sb_wdata", dmem_wdata_o, 32'hDDDDDDDD);
    bus(2, 0, 32'd0, 20, rq, st);
    check("sb_req_cycles", rq, 32'd3);
    check("sb_stall_cycles", st, 32'd3);

    for (int k = 0; k < 4; k++) begin
      drive(32'h2002, 32'd0, ld_rd[k], 1'b1, 1'b1, 1'b0, ld_f3[k]);
      push(ld_dt[k], 1'b1, ld_rd[k], ld_rw[k], 1'b0, 2'd0);
      tick();
      idle_in();
      check("ld_addr", dmem_addr_o, 32'h2000);
      check("ld_be", {28'd0, dmem_be_o}, 32'h0);
      check("ld_we", {31'd0, dmem_we_o}, 32'd0);
      bus(0, 1, 32'h80F17F00, 20, rq, st);
      check("ld_req_cycles", rq, 32'd1);
      check("ld_stall_cycles", st, 32'd2);
    end

    drive(32'h2001, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 3'd2);
    push(32'd0, 1'b0, 5'd8, 1'b0, 1'b1, 2'd0);
    tick();
    idle_in();
    check("mis_req", {31'd0, dmem_req_o}, 32'd0);
    check("mis_stall", {31'd0, stall_o}, 32'd0);
    drive(32'h2004, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'd3);
    push(32'd0, 1'b0, 5'd9, 1'b0, 1'b1, 2'd1);
    tick();
    drive(32'h2004, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd4);
    push(32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'd1);
    check("ill_req", {31'd0, dmem_req_o}, 32'd0);
    tick();
    idle_in();
    check("ill_st_req", {31'd0, dmem_req_o}, 32'd0);
    tick();

    drive(32'h3000, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'd2);
    push(32'd0, 1'b0, 5'd9, 1'b0, 1'b1, 2'd2);
    tick();
    idle_in();
    bus(-1, 0, 32'd0, 20, rq, st);
    check("to_req_cycles", rq, 32'd4);
    check("to_stall_cycles", st, 32'd4);
    drive(32'h1234, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
    push(32'h1234, 1'b1, 5'd3, 1'b1, 1'b0, 2'd0);
    tick();
    idle_in();
    tick();

    drive(32'h2000, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 3'd2);
    tick();
    idle_in();
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check("rw_wait_stall", {31'd0, stall_o}, 32'd1);
    check("rw_wait_req", {31'd0, dmem_req_o}, 32'd0);
    base = wb_count;
    reset_i = 1'b0;
    #1;
    check("rw_stall", {31'd0, stall_o}, 32'd0);
    check("rw_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rw_wb_data", wb_data_o, 32'd0);
    check("rw_wb_reg", {27'd0, wb_reg_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hCAFEF00D;
    tick();
    dmem_rvalid_i = 1'b0;
    tick();
    tick();
    check("rw_late_rvalid", wb_count - base, 32'd0);

    drive(32'h55, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
    push(32'h55, 1'b1, 5'd1, 1'b1, 1'b0, 2'd0);
    tick();
    idle_in();
    tick();
    tick();
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
